piece_dispatcher: RTL and testbench

PIECE_DISPATCHER -- requirements
Module: piece_dispatcher

---
 rtl/piece_dispatcher_pkg.sv | 6 +
 rtl/piece_queue.sv | 42 ++++
 rtl/piece_dispatcher.sv | 70 +++++++
 tb/tb_piece_dispatcher.sv | 116 +++++++++++
 4 files changed

// File: rtl/piece_dispatcher_pkg.sv
// piece_dispatcher_pkg: shared constants and state type for the piece dispatcher
package piece_dispatcher_pkg;
    localparam int NUM_PIECES = 5;
    localparam int ID_W = 3;
    typedef enum logic {FILL, RUN} state_t;
endpackage

// File: rtl/piece_queue.sv
// piece_queue: circular buffer of upcoming pieces with simultaneous push and pop
module piece_queue #(
    parameter int DEPTH = 3,
    parameter int W = 3,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [W-1:0]  second,
    output logic [W-1:0]  tail,
    output logic [CW-1:0] count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] rd, wr;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction
    assign head = mem[rd];
    assign second = mem[inc(rd)];
    assign tail = mem[(wr == '0) ? PW'(DEPTH - 1) : wr - PW'(1)];
    // storage write; contents are only observed through count-gated outputs
    always_ff @(posedge clk) begin
        if (push) mem[wr] <= din;
    end
    // pointers and occupancy; the caller guarantees push only with room and pop only when nonempty
    always_ff @(posedge clk) begin
        if (reset) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (push) wr <= inc(wr);
            if (pop) rd <= inc(rd);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/piece_dispatcher.sv
// piece_dispatcher: filters random candidates into a piece queue and deals the head on request
module piece_dispatcher #(
    parameter int NUM_PIECES = piece_dispatcher_pkg::NUM_PIECES,
    parameter int QUEUE_DEPTH = 3,
    parameter int MAX_REROLL = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [31:0]                       rnd_data,
    input  logic                              piece_req,
    output logic                              piece_valid,
    output logic [piece_dispatcher_pkg::ID_W-1:0] piece_id,
    output logic [piece_dispatcher_pkg::ID_W-1:0] preview_id,
    output logic [15:0]                       dealt_count
);
    import piece_dispatcher_pkg::*;
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int RW = MAX_REROLL > 0 ? $clog2(MAX_REROLL + 1) : 1;
    state_t state, state_nx;
    logic [ID_W-1:0] cand, head, second, tail;
    logic [CW-1:0] count;
    logic [RW-1:0] reroll;
    logic legal, same, reject, pop, push, full;
    assign cand = rnd_data[ID_W-1:0];
    assign legal = (rnd_data[31:ID_W] == '0) && (int'(cand) < NUM_PIECES);
    assign full = count == CW'(QUEUE_DEPTH);
    assign same = (count != '0) && (cand == tail);
    assign reject = enable && legal && same && (int'(reroll) < MAX_REROLL);
    assign pop = piece_req && piece_valid;
    assign push = enable && legal && !reject && (!full || pop);
    piece_queue #(.DEPTH(QUEUE_DEPTH), .W(ID_W), .CW(CW)) u_queue (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din(cand),
        .head(head),
        .second(second),
        .tail(tail),
        .count(count)
    );
    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= FILL;
        else state <= state_nx;
    end
    // enter RUN the edge the queue becomes full; RUN is left only through reset
    always_comb begin
        state_nx = state;
        piece_valid = 1'b0;
        piece_id = '0;
        preview_id = '0;
        if (state == FILL && (full || (push && count == CW'(QUEUE_DEPTH - 1)))) state_nx = RUN;
        piece_valid = (state == RUN) && (count != '0);
        piece_id = (count != '0) ? head : '0;
        preview_id = (count > CW'(1)) ? second : '0;
    end
    // same-as-tail reroll tracking; frozen while enable is low
    always_ff @(posedge clk) begin
        if (reset) reroll <= '0;
        else if (reject) reroll <= reroll + RW'(1);
        else if (enable && legal) reroll <= '0;
    end
    // dealt counter; counts pops while enabled, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (reset) dealt_count <= '0;
        else if (pop && enable) dealt_count <= dealt_count + 16'd1;
    end
endmodule

// File: tb/tb_piece_dispatcher.sv
// tb_piece_dispatcher: directed table, corner sequences and randomized model check
module tb_piece_dispatcher;
    localparam int NP = 5, QD = 3, MR = 1;
    logic clk = 0, reset = 1, enable = 0, piece_req = 0;
    logic [31:0] rnd_data = 0;
    logic piece_valid;
    logic [2:0] piece_id, preview_id;
    logic [15:0] dealt_count;
    int vectors = 0, miscompares = 0;
    int mq[$];
    bit running = 0;
    int reroll = 0, dealt = 0;
    typedef struct {bit rst; bit en; logic [31:0] rnd; bit req; bit v; int id; int pv; int d;} vec_t;
    vec_t tbl[$];

    piece_dispatcher #(.NUM_PIECES(NP), .QUEUE_DEPTH(QD), .MAX_REROLL(MR)) dut (
        .clk(clk), .reset(reset), .enable(enable), .rnd_data(rnd_data), .piece_req(piece_req),
        .piece_valid(piece_valid), .piece_id(piece_id), .preview_id(preview_id), .dealt_count(dealt_count)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit r, input bit e, input logic [31:0] d, input bit q);
        bit pop, pushv, legal;
        int c;
        if (r) begin
            mq.delete();
            running = 0;
            reroll = 0;
            dealt = 0;
            return;
        end
        c = int'(d & 32'd7);
        legal = ((d >> 3) == 0) && (c < NP);
        pop = q && running && mq.size() > 0;
        pushv = 0;
        if (e && legal) begin
            if (mq.size() > 0 && c == mq[$] && reroll < MR) reroll++;
            else begin
                reroll = 0;
                if (mq.size() < QD || pop) pushv = 1;
            end
        end
        if (pop) begin
            void'(mq.pop_front());
            if (e) dealt = (dealt + 1) % 65536;
        end
        if (pushv) mq.push_back(c);
        if (!running && mq.size() == QD) running = 1;
    endtask

    task automatic compare(input string name, input bit ev, input int eid, input int epv, input int ed);
        vectors++;
        if (piece_valid !== ev || int'(piece_id) != eid || int'(preview_id) != epv || int'(dealt_count) != ed
            || $isunknown({piece_valid, piece_id, preview_id, dealt_count})) begin
            miscompares++;
            $display("FAIL %s: got valid=%0b id=%0d preview=%0d dealt=%0d, expected valid=%0b id=%0d preview=%0d dealt=%0d",
                     name, piece_valid, piece_id, preview_id, dealt_count, ev, eid, epv, ed);
        end
    endtask

    task automatic drive(input bit r, input bit e, input logic [31:0] d, input bit q);
        reset = r;
        enable = e;
        rnd_data = d;
        piece_req = q;
        @(posedge clk);
        model_step(r, e, d, q);
        @(negedge clk);
    endtask

    task automatic model_check(input string name, input bit r, input bit e, input logic [31:0] d, input bit q);
        drive(r, e, d, q);
        compare(name, running && mq.size() > 0, mq.size() > 0 ? mq[0] : 0, mq.size() > 1 ? mq[1] : 0, dealt);
    endtask

    initial begin
        int sel;
        logic [31:0] d;
        tbl.push_back('{1, 0, 32'd0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 32'd2, 0, 0, 2, 0, 0});
        tbl.push_back('{0, 1, 32'd4, 0, 0, 2, 4, 0});
        tbl.push_back('{0, 1, 32'd1, 0, 1, 2, 4, 0});
        tbl.push_back('{0, 1, 32'd7, 0, 1, 2, 4, 0});
        tbl.push_back('{0, 1, 32'h9, 0, 1, 2, 4, 0});
        tbl.push_back('{0, 1, 32'h80000003, 0, 1, 2, 4, 0});
        tbl.push_back('{0, 1, 32'd7, 1, 1, 4, 1, 1});
        tbl.push_back('{0, 1, 32'd1, 0, 1, 4, 1, 1});
        tbl.push_back('{0, 1, 32'd1, 0, 1, 4, 1, 1});
        tbl.push_back('{0, 1, 32'd3, 1, 1, 1, 1, 2});
        tbl.push_back('{0, 1, 32'd0, 1, 1, 1, 3, 3});
        tbl.push_back('{1, 1, 32'd2, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 32'd2, 1, 0, 0, 0, 0});
        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].rnd, tbl[i].req);
            compare($sformatf("table%0d", i), tbl[i].v, tbl[i].id, tbl[i].pv, tbl[i].d);
        end
        model_check("fill_a", 0, 1, 32'd3, 0);
        model_check("fill_b", 0, 1, 32'd0, 0);
        model_check("fill_c", 0, 1, 32'd4, 0);
        model_check("pop_disabled", 0, 0, 32'd2, 1);
        for (int i = 0; i < 3; i++) model_check($sformatf("drain%0d", i), 0, 1, 32'd6, 1);
        model_check("req_when_empty", 0, 1, 32'd6, 1);
        model_check("refill_in_run", 0, 1, 32'd2, 1);
        model_check("pop_after_refill", 0, 1, 32'd5, 1);
        model_check("rst_again", 1, 1, 32'd0, 1);
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 9);
            d = (sel < 7) ? 32'($urandom_range(0, 7)) : (sel == 7) ? $urandom : (32'($urandom_range(1, 3)) << 3) | 32'($urandom_range(0, 7));
            model_check($sformatf("rand%0d", i), $urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, d, $urandom_range(0, 2) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
